// File: rtl/mul_xy_pkg.sv
// rtl/mul_xy_pkg.sv - shared state encoding and default widths for mul_xy
// Default widths match the div_xy coordinate datapath.
package mul_xy_pkg;

  localparam int M_DEF = 25;
  localparam int N_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_xy.sv
// rtl/mul_xy.sv - sequential shift-add unsigned multiplier, one partial product per clock
// Rebuilds quotient*divisor for the stroke/step generators under start/busy/done.
module mul_xy
  import mul_xy_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [M:0]     x,
  input  logic [N:0]     y,
  output logic           busy,
  output logic           done,
  output logic [M+N+1:0] prod,
  output logic [M:0]     q,
  output logic           ovf
);

  localparam int PW = M + N + 2;
  localparam int CW = (N > 0) ? $clog2(N + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N);

  state_t          state;
  state_t          state_nxt;
  logic [M:0]      x_reg;
  logic [N:0]      y_reg;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   acc_nxt;
  logic [PW-1:0]   addend;
  logic [CW-1:0]   cnt;
  logic            zero_op;
  logic            last;

  assign zero_op = (x == '0) || (y == '0);
  assign last    = (cnt == CNT_LAST);

  // Full-width accumulate: the product fits in PW bits, so no wrap is possible.
  always_comb begin
    addend = '0;
    if (y_reg[cnt]) begin
      addend = PW'(x_reg) << cnt;
    end
    acc_nxt = acc + addend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = zero_op ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result registers are kept apart from acc so they hold through the next RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg <= '0;
      y_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      prod  <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_reg <= x;
            y_reg <= y;
            acc   <= '0;
            cnt   <= '0;
            if (zero_op) begin
              prod <= '0;
              ovf  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            prod <= acc_nxt;
            ovf  <= |acc_nxt[PW-1:M+1];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign q    = prod[M:0];

endmodule
